// File: rtl/trencadis_pulse_train_generator.sv
// Purpose : CH-channel pulse/PWM generator. Each channel has a programmable period counter,
//           a tail-aligned high width, and a CONT, ONESHOT or BURST mode.
// Latency : outputs are registered; busy_o rises and the phase count starts the cycle after the starting edge.
// Backpr. : none. The block only sources strobes, so nothing downstream can stall it.
//
// Ports
//   clk_i, rst_i  clock and asynchronous active-high reset
//   en_i[CH]      per-channel enable; low aborts the channel to IDLE on the next edge without a done_o
//   start_i[CH]   per-channel start strobe, used only in ONESHOT/BURST while the channel is IDLE
//   sync_i        global phase realign: every RUN channel restarts its phase count at 0
//   mode_i        2 bits/channel: 00 CONT, 01 ONESHOT, 10 BURST, 11 CONT
//   period_i      SIZE bits/channel, max count M; the period is M+1 cycles
//   width_i       SIZE bits/channel, high cycles W at the end of each period (clamped to M)
//   burst_i       BURST_W bits/channel, number of periods N in a burst
//   pulse_o       registered pulse/PWM output
//   busy_o        the channel is in RUN
//   done_o        one-cycle strobe when a ONESHOT/BURST finishes
module trencadis_pulse_train_generator #(
  parameter int SIZE    = 8,
  parameter int CH      = 4,
  parameter int BURST_W = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [CH-1:0]        en_i,
  input  logic [CH-1:0]        start_i,
  input  logic                 sync_i,
  input  logic [2*CH-1:0]      mode_i,
  input  logic [SIZE*CH-1:0]   period_i,
  input  logic [SIZE*CH-1:0]   width_i,
  input  logic [BURST_W*CH-1:0] burst_i,
  output logic [CH-1:0]        pulse_o,
  output logic [CH-1:0]        busy_o,
  output logic [CH-1:0]        done_o
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  // The width is clamped to M, so the period always keeps at least one low cycle (j=0).
  function automatic logic [SIZE-1:0] width_eff(input logic [SIZE-1:0] m, input logic [SIZE-1:0] w);
    return (w > m) ? m : w;
  endfunction

  // High for j in [P-Weff, P-1], which is the same as j > M-Weff.
  // M-Weff cannot underflow because Weff <= M. Weff=0 never drives the output high.
  function automatic logic high_at(input logic [SIZE-1:0] j, input logic [SIZE-1:0] m,
                                   input logic [SIZE-1:0] w);
    logic [SIZE-1:0] we;
    we = width_eff(m, w);
    return (we != '0) && (j > (m - we));
  endfunction

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [1:0]         mode_in;
    logic [SIZE-1:0]    m_in;
    logic [SIZE-1:0]    w_in;
    logic [BURST_W-1:0] n_in;
    logic               cont_in;

    state_t             state;
    logic [SIZE-1:0]    j;       // phase count within the current period
    logic [SIZE-1:0]    m_q;
    logic [SIZE-1:0]    w_q;
    logic [BURST_W-1:0] rem;     // periods left in the burst, including the current one
    logic               cont_q;
    logic               pulse_q;
    logic               busy_q;
    logic               done_q;

    assign mode_in = mode_i[2*c +: 2];
    assign m_in    = period_i[SIZE*c +: SIZE];
    assign w_in    = width_i[SIZE*c +: SIZE];
    assign cont_in = (mode_in == 2'b00) || (mode_in == 2'b11);
    // A ONESHOT is a burst of exactly one period.
    assign n_in    = (mode_in == 2'b01) ? BURST_W'(1) : burst_i[BURST_W*c +: BURST_W];

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state   <= ST_IDLE;
        j       <= '0;
        m_q     <= '0;
        w_q     <= '0;
        rem     <= '0;
        cont_q  <= 1'b0;
        pulse_q <= 1'b0;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        done_q <= 1'b0;
        if (!en_i[c]) begin
          // An abort takes priority over everything and never reports completion.
          state   <= ST_IDLE;
          j       <= '0;
          pulse_q <= 1'b0;
          busy_q  <= 1'b0;
        end else begin
          case (state)
            ST_IDLE: begin
              pulse_q <= 1'b0;
              j       <= '0;
              if (cont_in) begin
                state  <= ST_RUN;
                cont_q <= 1'b1;
                m_q    <= m_in;
                w_q    <= w_in;
                busy_q <= 1'b1;
              end else if (start_i[c]) begin
                if ((n_in == '0) || (m_in == '0)) begin
                  // An empty burst completes at once and the channel stays IDLE.
                  done_q <= 1'b1;
                end else begin
                  state  <= ST_RUN;
                  cont_q <= 1'b0;
                  m_q    <= m_in;
                  w_q    <= w_in;
                  rem    <= n_in;
                  busy_q <= 1'b1;
                end
              end
            end
            ST_RUN: begin
              if (sync_i) begin
                // The phase restarts, and the burst keeps the periods it has already completed.
                // A sync on the wrap edge wins, so that period is not counted.
                j       <= '0;
                pulse_q <= 1'b0;
              end else if (j == m_q) begin
                j       <= '0;
                pulse_q <= 1'b0;
                if (cont_q) begin
                  // CONT picks up new period and width only at the period boundary.
                  m_q <= m_in;
                  w_q <= w_in;
                end else if (rem == BURST_W'(1)) begin
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                end else begin
                  rem <= rem - BURST_W'(1);
                end
              end else begin
                j       <= j + SIZE'(1);
                pulse_q <= high_at(j + SIZE'(1), m_q, w_q);
              end
            end
            default: begin
              state   <= ST_IDLE;
              pulse_q <= 1'b0;
              busy_q  <= 1'b0;
            end
          endcase
        end
      end
    end

    assign pulse_o[c] = pulse_q;
    assign busy_o[c]  = busy_q;
    assign done_o[c]  = done_q;
  end

endmodule
